// File: rtl/multichannel_thermometer_stream_gen.sv
// rtl/multichannel_thermometer_stream_gen.sv - multi-channel serial thermometer encoder with valid/ready streaming
module multichannel_thermometer_stream_gen #(
   parameter int N          = 4,
   parameter int CH         = 4,
   parameter int ONES_FIRST = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic            mode_signed,
   input  logic [CH*N-1:0] binary_in,
   input  logic            out_ready,
   output logic [CH-1:0]   serial_out,
   output logic            out_valid,
   output logic            out_last,
   output logic            busy,
   output logic            done
);

   // Stream length L = 2^N-1 and the index of its final column.
   localparam logic [N-1:0] LEN      = {N{1'b1}};
   localparam logic [N-1:0] IDX_LAST = LEN - N'(1);
   // Flipping the MSB maps a two's-complement word onto its offset-binary count.
   localparam logic [N-1:0] MSB_MASK = N'(1) << (N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [N-1:0]      bit_idx;
   logic [CH*N-1:0]   thr;
   logic [CH*N-1:0]   load_thr;
   logic [N-1:0]      next_idx;

   // Thermometer column for a given bit index and set of per-channel thresholds.
   function automatic logic [CH-1:0] column(input logic [N-1:0] idx,
                                            input logic [CH*N-1:0] t);
      logic [CH-1:0] col;
      logic [N-1:0]  tc;
      col = '0;
      for (int c = 0; c < CH; c++) begin
         tc = t[c*N +: N];
         if (ONES_FIRST != 0)
            col[c] = (idx < tc);
         else
            col[c] = (idx >= (LEN - tc));
      end
      return col;
   endfunction

   // Convert the incoming words into per-channel ones counts, honouring signed mode.
   always_comb begin
      load_thr = '0;
      for (int c = 0; c < CH; c++) begin
         load_thr[c*N +: N] = binary_in[c*N +: N] ^ (mode_signed ? MSB_MASK : '0);
      end
   end

   assign next_idx = bit_idx + N'(1);

   // Control FSM; every output is a register so the next column is precomputed on each step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_idx    <= '0;
         thr        <= '0;
         serial_out <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (abort) begin
         // Cancel wins over start and over a pending transfer; latched words are kept.
         state      <= IDLE;
         bit_idx    <= '0;
         serial_out <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  thr        <= load_thr;
                  bit_idx    <= '0;
                  serial_out <= column('0, load_thr);
                  out_valid  <= 1'b1;
                  out_last   <= (IDX_LAST == '0);
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               // out_valid is always high here, so out_ready alone marks a transfer.
               if (out_ready) begin
                  if (out_last) begin
                     serial_out <= '0;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else begin
                     bit_idx    <= next_idx;
                     serial_out <= column(next_idx, thr);
                     out_last   <= (next_idx == IDX_LAST);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               serial_out <= '0;
               out_valid  <= 1'b0;
               out_last   <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multichannel_thermometer_stream_gen.sv
// tb/tb_multichannel_thermometer_stream_gen.sv - directed table-driven bench for the thermometer stream generator
module tb_multichannel_thermometer_stream_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        mode_signed;
   logic [15:0] binary_in;
   logic        out_ready;
   logic [3:0]  serial_out;
   logic        out_valid;
   logic        out_last;
   logic        busy;
   logic        done;
   logic [3:0]  serial_out_z;
   logic        out_valid_z;
   logic        out_last_z;
   logic        busy_z;
   logic        done_z;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        md;
      logic [15:0] words;
      logic [15:0] exp_thr;
   } vec_t;

   vec_t vecs [4];

   multichannel_thermometer_stream_gen #(.N(4), .CH(4), .ONES_FIRST(1)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .mode_signed(mode_signed), .binary_in(binary_in), .out_ready(out_ready),
      .serial_out(serial_out), .out_valid(out_valid), .out_last(out_last),
      .busy(busy), .done(done)
   );

   multichannel_thermometer_stream_gen #(.N(4), .CH(4), .ONES_FIRST(0)) dut_z (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .mode_signed(mode_signed), .binary_in(binary_in), .out_ready(out_ready),
      .serial_out(serial_out_z), .out_valid(out_valid_z), .out_last(out_last_z),
      .busy(busy_z), .done(done_z)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Expected column k for both orderings, from hand-entered thresholds.
   task automatic check_col(input string nm, input int k, input logic [15:0] et);
      logic [3:0] e1;
      logic [3:0] e0;
      int t;
      for (int c = 0; c < 4; c++) begin
         t = int'(et[c*4 +: 4]);
         e1[c] = (k < t);
         e0[c] = (k >= 15 - t);
      end
      chk($sformatf("%s col%0d serial", nm, k), 32'(serial_out), 32'(e1));
      chk($sformatf("%s col%0d serial_z", nm, k), 32'(serial_out_z), 32'(e0));
      chk($sformatf("%s col%0d valid", nm, k), 32'(out_valid), 32'd1);
      chk($sformatf("%s col%0d last", nm, k), 32'(out_last), 32'(k == 14));
      chk($sformatf("%s col%0d busy", nm, k), 32'(busy), 32'd1);
   endtask

   task automatic run_stream(input string nm, input logic md, input logic [15:0] w,
                             input logic [15:0] et, input logic start_in_done);
      mode_signed = md;
      binary_in   = w;
      out_ready   = 1'b1;
      start       = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 15; k++) begin
         check_col(nm, k, et);
         tick();
      end
      chk({nm, " done pulse"}, 32'(done), 32'd1);
      chk({nm, " done valid"}, 32'(out_valid), 32'd0);
      chk({nm, " done busy"}, 32'(busy), 32'd1);
      start = start_in_done;
      tick();
      start = 1'b0;
      chk({nm, " post done"}, 32'(done), 32'd0);
      chk({nm, " post busy"}, 32'(busy), 32'd0);
      chk({nm, " post valid"}, 32'(out_valid), 32'd0);
      tick();
      chk({nm, " idle valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int idx;
      int cyc;
      int ones;

      vecs[0] = '{"unsigned_0_5_15_8", 1'b0, 16'h8F50, 16'h8F50};
      vecs[1] = '{"signed_m8_m1_0_7",  1'b1, 16'h70F8, 16'hF870};
      vecs[2] = '{"unsigned_1_14_7_3", 1'b0, 16'h37E1, 16'h37E1};
      vecs[3] = '{"signed_5_m6_1_m4",  1'b1, 16'hC1A5, 16'h492D};

      reset = 1'b1; start = 1'b0; abort = 1'b0; mode_signed = 1'b0;
      binary_in = '0; out_ready = 1'b1;
      #3;
      chk("reset serial", 32'(serial_out), 32'd0);
      chk("reset valid", 32'(out_valid), 32'd0);
      chk("reset last", 32'(out_last), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      reset = 1'b0;
      tick();

      for (int v = 0; v < 4; v++)
         run_stream(vecs[v].name, vecs[v].md, vecs[v].words, vecs[v].exp_thr, 1'b0);

      // start during the DONE cycle must be ignored
      run_stream("start_in_done", 1'b0, 16'h8F50, 16'h8F50, 1'b1);

      // backpressure: out_ready pattern 1,0,0,1,0,0,...
      mode_signed = 1'b0; binary_in = 16'h8F55; start = 1'b1;
      tick();
      start = 1'b0;
      idx = 0; cyc = 0; ones = 0;
      while (idx < 15 && cyc < 200) begin
         check_col("bp", idx, 16'h8F55);
         out_ready = ((cyc % 3) == 0);
         if (out_ready) ones += int'(serial_out[0]);
         tick();
         if (out_ready) idx++;
         cyc++;
      end
      chk("bp transfers", 32'(idx), 32'd15);
      chk("bp ch0 ones", 32'(ones), 32'd5);
      chk("bp cycles", 32'(cyc), 32'd43);
      chk("bp done", 32'(done), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp done clear", 32'(done), 32'd0);

      // start mid-stream ignored, then abort at column 9
      binary_in = 16'h8F50; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         check_col("ab", k, 16'h8F50);
         if (k == 6) begin
            binary_in = 16'hFFFF;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      check_col("ab", 9, 16'h8F50);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort valid", 32'(out_valid), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort serial", 32'(serial_out), 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("abort no done %0d", k), 32'(done), 32'd0);
         tick();
      end
      run_stream("after_abort", 1'b0, 16'h37E1, 16'h37E1, 1'b0);

      // asynchronous reset at column 4
      binary_in = 16'h8F50; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_col("rst", k, 16'h8F50);
         tick();
      end
      #2;
      reset = 1'b1;
      #1;
      chk("async reset serial", 32'(serial_out), 32'd0);
      chk("async reset valid", 32'(out_valid), 32'd0);
      chk("async reset last", 32'(out_last), 32'd0);
      chk("async reset busy", 32'(busy), 32'd0);
      chk("async reset done", 32'(done), 32'd0);
      #1;
      reset = 1'b0;
      tick();
      run_stream("after_reset", 1'b0, 16'h8F50, 16'h8F50, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
